// File: rtl/multiword_add_seq.sv
// Multi-word adder: one N-bit ripple adder reused over WORDS cycles, LSB chunk first.
// Define WADD_OVF_EN to add the registered signed-overflow output ovf.
module multiword_add_seq #(
  parameter int unsigned N     = 32,
  parameter int unsigned WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   sum,
  output logic                 cout
`ifdef WADD_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam int unsigned W    = N * WORDS;
  localparam int unsigned CntW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    b_sh_q, b_sh_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic [CntW-1:0] cnt_q, cnt_d;
`ifdef WADD_OVF_EN
  logic            a_msb_q, a_msb_d;
  logic            b_msb_q, b_msb_d;
  logic            ovf_q, ovf_d;
`endif

  logic [N-1:0]    add_s;
  logic            add_co;
  logic [W+N-1:0]  sum_cat;

  // Single N-bit ripple adder on the low chunk of the operand shift registers.
  always_comb begin
    logic [N:0] c;
    c     = '0;
    c[0]  = carry_q;
    add_s = '0;
    for (int i = 0; i < N; i++) begin
      add_s[i] = a_sh_q[i] ^ b_sh_q[i] ^ c[i];
      c[i+1]   = (a_sh_q[i] & b_sh_q[i]) | (c[i] & (a_sh_q[i] ^ b_sh_q[i]));
    end
    add_co = c[N];
  end

  // New chunk enters at the MSB end; after WORDS shifts the result is aligned.
  assign sum_cat = {add_s, sum_q};

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    cnt_d     = cnt_q;
`ifdef WADD_OVF_EN
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
    ovf_d     = ovf_q;
`endif
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StCalc;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
`ifdef WADD_OVF_EN
          a_msb_d = a[W-1];
          b_msb_d = b[W-1];
`endif
        end
      end
      StCalc: begin
        sum_d   = sum_cat[W+N-1:N];
        carry_d = add_co;
        a_sh_d  = a_sh_q >> N;
        b_sh_d  = b_sh_q >> N;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          cout_d  = add_co;
`ifdef WADD_OVF_EN
          ovf_d   = (a_msb_q == b_msb_q) & (add_s[N-1] != a_msb_q);
`endif
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef WADD_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef WADD_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef WADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq: an N=8/WORDS=4 instance for directed cases and an
// N=32/WORDS=1 instance for back-to-back streaming; expected results come from a queue.
module tb_multiword_add_seq;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv0, ir0, cin0, ov0, or0, cout0;
  logic [31:0] a0, b0, sum0;
  logic        iv1, ir1, cin1, ov1, or1, cout1;
  logic [31:0] a1, b1, sum1;
`ifdef WADD_OVF_EN
  logic        ovf0, ovf1;
`endif

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  multiword_add_seq #(.N(8), .WORDS(4)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv0),
    .in_ready  (ir0),
    .a         (a0),
    .b         (b0),
    .cin       (cin0),
    .out_valid (ov0),
    .out_ready (or0),
    .sum       (sum0),
`ifdef WADD_OVF_EN
    .ovf       (ovf0),
`endif
    .cout      (cout0)
  );

  multiword_add_seq #(.N(32), .WORDS(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv1),
    .in_ready  (ir1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .out_valid (ov1),
    .out_ready (or1),
    .sum       (sum1),
`ifdef WADD_OVF_EN
    .ovf       (ovf1),
`endif
    .cout      (cout1)
  );

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic ci);
    logic [32:0] t;
    exp_t        e;
    t      = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    e.sum  = t[31:0];
    e.cout = t[32];
    e.ovf  = (x[31] == y[31]) && (t[31] != x[31]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [31:0] x, input logic [31:0] y, input logic ci);
    int t = 0;
    while (!ir0 && t < 50) begin
      tick();
      t++;
    end
    chk("send_in_ready", {31'd0, ir0}, 32'd1);
    iv0  = 1'b1;
    a0   = x;
    b0   = y;
    cin0 = ci;
    @(posedge clk);
    if (ir0) q0.push_back(model(x, y, ci));
    #1;
    iv0 = 1'b0;
  endtask

  task automatic get0(input string tag, output int lat);
    exp_t e;
    lat = 0;
    while (!ov0 && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_out_valid"}, {31'd0, ov0}, 32'd1);
    chk({tag, "_queue"}, (q0.size() != 0) ? 32'd1 : 32'd0, 32'd1);
    if (ov0 && q0.size() != 0) begin
      e = q0.pop_front();
      chk({tag, "_sum"}, sum0, e.sum);
      chk({tag, "_cout"}, {31'd0, cout0}, {31'd0, e.cout});
`ifdef WADD_OVF_EN
      chk({tag, "_ovf"}, {31'd0, ovf0}, {31'd0, e.ovf});
`endif
    end
    or0 = 1'b1;
    tick();
    or0 = 1'b0;
  endtask

  initial begin
    int          lat;
    int          idx, got, cyc, last;
    logic        acc;
    exp_t        e;
    logic [31:0] ra[10];
    logic [31:0] rb[10];
    logic        rc[10];

    // Reset with in_valid asserted on both instances: must be ignored.
    rst_n = 1'b0;
    iv0 = 1'b1; a0 = 32'h1234_5678; b0 = 32'h1111_1111; cin0 = 1'b1; or0 = 1'b0;
    iv1 = 1'b1; a1 = 32'hdead_beef; b1 = 32'h1; cin1 = 1'b0; or1 = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", {31'd0, ov0}, 32'd0);
    chk("rst_sum", sum0, 32'd0);
    chk("rst_cout", {31'd0, cout0}, 32'd0);
    rst_n = 1'b1;
    iv0 = 1'b0;
    iv1 = 1'b0;
    chk("rel_in_ready", {31'd0, ir0}, 32'd1);
    tick();
    chk("rel_in_ready_hold", {31'd0, ir0}, 32'd1);
    chk("rel_dut1_in_ready", {31'd0, ir1}, 32'd1);

    // Case 1: carry out of chunk 0, latency check.
    send0(32'h0000_00ff, 32'h0000_0001, 1'b0);
    get0("t1", lat);
    chk("t1_latency", lat, 32'd4);
    chk("t1_out_valid_low", {31'd0, ov0}, 32'd0);
    chk("t1_sum_hold", sum0, 32'h0000_0100);

    // Case 2: carry ripples through every chunk.
    send0(32'hffff_ffff, 32'h0000_0000, 1'b1);
    get0("t2", lat);

    // Case 3: backpressure while other operands are offered.
    send0(32'h0000_00ff, 32'h0000_0001, 1'b0);
    lat = 0;
    while (!ov0 && lat < 20) begin
      tick();
      lat++;
    end
    iv0 = 1'b1; a0 = 32'hdead_beef; b0 = 32'h0000_0001; cin0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_out_valid", {31'd0, ov0}, 32'd1);
      chk("t3_in_ready", {31'd0, ir0}, 32'd0);
      chk("t3_sum", sum0, 32'h0000_0100);
      chk("t3_cout", {31'd0, cout0}, 32'd0);
      tick();
    end
    iv0 = 1'b0;
    get0("t3", lat);
    repeat (6) tick();
    chk("t3_not_consumed", {31'd0, ov0}, 32'd0);
    chk("t3_idle", {31'd0, ir0}, 32'd1);

    // Case 4: reset in the second CALC cycle discards the operation.
    send0(32'hffff_ffff, 32'h0000_0000, 1'b1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q0.delete();
    chk("t4_out_valid", {31'd0, ov0}, 32'd0);
    chk("t4_sum", sum0, 32'd0);
    chk("t4_cout", {31'd0, cout0}, 32'd0);
    chk("t4_in_ready", {31'd0, ir0}, 32'd1);
`ifdef WADD_OVF_EN
    chk("t4_ovf", {31'd0, ovf0}, 32'd0);
`endif
    repeat (6) tick();
    chk("t4_no_partial", {31'd0, ov0}, 32'd0);
    send0(32'd3, 32'd4, 1'b0);
    get0("t4_next", lat);

    // Case 5: signed-overflow vectors (ovf checked when the feature is built in).
    send0(32'h7fff_ffff, 32'h0000_0001, 1'b0);
    get0("t5a", lat);
    send0(32'h8000_0000, 32'h8000_0000, 1'b0);
    get0("t5b", lat);

    for (int i = 0; i < 3; i++) begin
      send0($urandom, $urandom, 1'($urandom_range(1, 0)));
      get0("rand0", lat);
    end

    // Case 6: WORDS=1 instance streaming with in_valid and out_ready held high.
    for (int i = 0; i < 10; i++) begin
      ra[i] = $urandom;
      rb[i] = $urandom;
      rc[i] = 1'($urandom_range(1, 0));
    end
    idx = 0; got = 0; cyc = 0; last = -1;
    or1 = 1'b1;
    iv1 = 1'b1; a1 = ra[0]; b1 = rb[0]; cin1 = rc[0];
    while (got < 10 && cyc < 200) begin
      if (ov1 && or1) begin
        chk("t6_queue", (q1.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk("t6_sum", sum1, e.sum);
          chk("t6_cout", {31'd0, cout1}, {31'd0, e.cout});
`ifdef WADD_OVF_EN
          chk("t6_ovf", {31'd0, ovf1}, {31'd0, e.ovf});
`endif
        end
        if (last >= 0) chk("t6_interval", cyc - last, 32'd3);
        last = cyc;
        got++;
      end
      acc = iv1 && ir1;
      if (acc) q1.push_back(model(a1, b1, cin1));
      tick();
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 10) begin
          a1 = ra[idx]; b1 = rb[idx]; cin1 = rc[idx];
        end else begin
          iv1 = 1'b0;
        end
      end
    end
    chk("t6_count", got, 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
